// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared sizing helpers for the scanned button debouncer and related
// pin-input blocks.
//   count_width(limit) : bits needed to hold a count of 0..limit
//                        ($clog2(limit+1), never less than 1)
//   idx_width(num)     : bits needed for a scan index over num channels
//                        ($clog2(num), never less than 1)
// -----------------------------------------------------------------------------
package debounce_pkg;

  function automatic int count_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  // A single channel still needs a 1-bit index so the port never collapses
  // to zero width.
  function automatic int idx_width(input int num);
    return (num < 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/input_sync_2ff.sv
// -----------------------------------------------------------------------------
// input_sync_2ff
// Parameterized-width two-flop synchronizer for asynchronous pin inputs.
// Every bit is synchronized independently; no bus coherence is implied.
// Ports:
//   i_Clk   : destination clock, rising edge
//   i_Rst   : asynchronous active-high reset, clears both stages
//   i_Async : raw asynchronous inputs (WIDTH bits)
//   o_Sync  : synchronized copy, two clocks behind i_Async
// -----------------------------------------------------------------------------
module input_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= i_Async;
      sync_reg <= meta_reg;
    end
  end

  assign o_Sync = sync_reg;

endmodule

// File: rtl/button_scan_debouncer.sv
// -----------------------------------------------------------------------------
// button_scan_debouncer
// Debounces NUM_BUTTONS raw inputs with a single shared compare/increment
// engine. A round-robin scan index visits one channel per clock; only that
// channel's count and debounced level may change on that clock.
// Ports:
//   i_Clk       : system clock, rising edge
//   i_Rst       : asynchronous active-high reset
//   i_Bouncy    : raw switch inputs (NUM_BUTTONS bits)
//   o_Debounced : filtered level per channel
//   o_Press     : one-cycle pulse when a channel commits 0 -> 1
//   o_Release   : one-cycle pulse when a channel commits 1 -> 0
//   o_Scan_Idx  : channel visited on the coming clock edge
// A channel commits after DEBOUNCE_LIMIT consecutive visits that disagree
// with its debounced level, so the filter time is about
// DEBOUNCE_LIMIT * NUM_BUTTONS clocks.
// -----------------------------------------------------------------------------
module button_scan_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEBOUNCE_LIMIT = 20
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst,
  input  logic [NUM_BUTTONS-1:0]            i_Bouncy,
  output logic [NUM_BUTTONS-1:0]            o_Debounced,
  output logic [NUM_BUTTONS-1:0]            o_Press,
  output logic [NUM_BUTTONS-1:0]            o_Release,
  output logic [idx_width(NUM_BUTTONS)-1:0] o_Scan_Idx
);

  localparam int IDX_W = idx_width(NUM_BUTTONS);
  localparam int CNT_W = count_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUTTONS - 1);

  logic [NUM_BUTTONS-1:0] sync_w;

  logic [IDX_W-1:0]       idx_reg;
  logic [IDX_W-1:0]       idx_next;
  logic [CNT_W-1:0]       count_reg  [NUM_BUTTONS];
  logic [CNT_W-1:0]       count_next [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] debounced_reg, debounced_next;
  logic [NUM_BUTTONS-1:0] press_reg, press_next;
  logic [NUM_BUTTONS-1:0] release_reg, release_next;

  logic [NUM_BUTTONS-1:0] visit;
  logic [NUM_BUTTONS-1:0] differ;
  logic [NUM_BUTTONS-1:0] at_limit;

  input_sync_2ff #(
    .WIDTH (NUM_BUTTONS)
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_Bouncy),
    .o_Sync  (sync_w)
  );

  // Wrap explicitly so non-power-of-two channel counts never visit a
  // channel that does not exist; with one channel this holds at 0.
  assign idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

  // Per-channel decode. Only the visited channel acts on differ/at_limit.
  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
    assign visit[gi]    = (idx_reg == IDX_W'(gi));
    assign differ[gi]   = sync_w[gi] ^ debounced_reg[gi];
    assign at_limit[gi] = (count_reg[gi] == LAST_CNT);
  end

  // Shared visit engine. The count is cleared on commit and on every
  // agreeing visit, so it never passes DEBOUNCE_LIMIT-1 and needs no
  // saturation. Pulses default low, so each lasts exactly one cycle and
  // only the visited channel can pulse.
  always_comb begin
    count_next     = count_reg;
    debounced_next = debounced_reg;
    press_next     = '0;
    release_next   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (visit[i]) begin
        if (!differ[i]) begin
          count_next[i] = '0;
        end else if (at_limit[i]) begin
          count_next[i]     = '0;
          debounced_next[i] = sync_w[i];
          press_next[i]     = sync_w[i];
          release_next[i]   = ~sync_w[i];
        end else begin
          count_next[i] = count_reg[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      idx_reg       <= '0;
      debounced_reg <= '0;
      press_reg     <= '0;
      release_reg   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        count_reg[i] <= '0;
      end
    end else begin
      idx_reg       <= idx_next;
      debounced_reg <= debounced_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      count_reg     <= count_next;
    end
  end

  assign o_Debounced = debounced_reg;
  assign o_Press     = press_reg;
  assign o_Release   = release_reg;
  assign o_Scan_Idx  = idx_reg;

endmodule

// File: tb/tb_button_scan_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_scan_debouncer
// Self-checking bench: a 4-channel / limit-3 instance checked every cycle
// against a behavioural model, plus table-driven latency vectors and
// hand-written corner sequences; a 1-channel / limit-1 instance checks the
// minimum configuration.
// -----------------------------------------------------------------------------
module tb_button_scan_debouncer;

  localparam int N      = 4;
  localparam int LIM    = 3;
  localparam int LAT_LO = 2 + (LIM - 1) * N;   // 10
  localparam int LAT_HI = 1 + LIM * N;         // 13

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] bouncy = '0;
  logic [N-1:0] deb, press, rel;
  logic [1:0]   scan;

  logic b1 = 1'b0;
  logic deb1, press1, rel1, scan1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  int press_cnt [N];
  int rel_cnt   [N];
  int press1_cnt = 0;
  int rel1_cnt   = 0;
  int           ev_cyc  [$];
  logic [N-1:0] ev_mask [$];
  logic [1:0]   ev_scan [$];

  always #5 clk = ~clk;

  button_scan_debouncer #(.NUM_BUTTONS(N), .DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Bouncy    (bouncy),
    .o_Debounced (deb),
    .o_Press     (press),
    .o_Release   (rel),
    .o_Scan_Idx  (scan)
  );

  button_scan_debouncer #(.NUM_BUTTONS(1), .DEBOUNCE_LIMIT(1)) dut1 (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Bouncy    (b1),
    .o_Debounced (deb1),
    .o_Press     (press1),
    .o_Release   (rel1),
    .o_Scan_Idx  (scan1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: input reaches the filter two edges after sampling; the
  // channel visited is (edges since reset) mod N. A channel flips when its
  // last LIM visit samples since the previous flip all oppose its level.
  // ---------------------------------------------------------------------------
  logic [N-1:0]   m_s1 = '0, m_s2 = '0, m_deb = '0, m_press = '0, m_rel = '0;
  int             m_idx = 0;
  logic [LIM-1:0] m_hist [N];
  int             m_seen [N];
  int             mk;
  logic           msmp;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0;
      m_seen[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0; m_rel = '0; m_idx = 0;
        for (int i = 0; i < N; i++) begin
          m_hist[i] = '0;
          m_seen[i] = 0;
        end
      end else begin
        mk      = m_idx;
        msmp    = m_s2[mk];
        m_press = '0;
        m_rel   = '0;
        m_hist[mk] = {m_hist[mk][LIM-2:0], msmp};
        m_seen[mk] = m_seen[mk] + 1;
        if (m_seen[mk] >= LIM && m_hist[mk] == {LIM{~m_deb[mk]}}) begin
          m_deb[mk] = msmp;
          if (msmp) m_press[mk] = 1'b1;
          else      m_rel[mk]   = 1'b1;
          m_seen[mk] = 0;
        end
        m_idx = (m_idx + 1) % N;
        m_s2  = m_s1;
        m_s1  = bouncy;
      end
    end
  end

  // Per-cycle comparison against the model plus pulse bookkeeping.
  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_en) begin
        check($sformatf("model_cycle%0d deb/press/rel/idx", cyc),
              {18'd0, deb, press, rel, scan},
              {18'd0, m_deb, m_press, m_rel, 2'(m_idx)});
        for (int i = 0; i < N; i++) begin
          press_cnt[i] += int'(press[i]);
          rel_cnt[i]   += int'(rel[i]);
        end
        if (press != '0) begin
          ev_cyc.push_back(cyc);
          ev_mask.push_back(press);
          ev_scan.push_back(scan);
        end
        press1_cnt += int'(press1);
        rel1_cnt   += int'(rel1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    press1_cnt = 0;
    rel1_cnt   = 0;
    ev_cyc.delete();
    ev_mask.delete();
    ev_scan.delete();
  endtask

  // Called just after driving at a negedge; edge 1 is the sampling edge e0,
  // so the returned value is L (output changes after edge e0 + L).
  task automatic measure(input int ch, input logic lvl, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && deb[ch] == lvl) lat = n - 1;
    end
  endtask

  typedef struct {
    int   ch;
    logic lvl;
    int   lo;
    int   hi;
    int   press_n;
    int   rel_n;
  } vec_t;

  vec_t vecs [6];
  int   lat, lat0, lat2, gmax, hold, pc;

  initial begin
    vecs[0] = '{1, 1'b1, LAT_LO, LAT_HI, 1, 0};
    vecs[1] = '{1, 1'b0, LAT_LO, LAT_HI, 0, 1};
    vecs[2] = '{0, 1'b1, LAT_LO, LAT_HI, 1, 0};
    vecs[3] = '{0, 1'b0, LAT_LO, LAT_HI, 0, 1};
    vecs[4] = '{3, 1'b1, LAT_LO, LAT_HI, 1, 0};
    vecs[5] = '{3, 1'b0, LAT_LO, LAT_HI, 0, 1};

    // Reset values, then release with 0101 already applied.
    bouncy = 4'b0101;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    check("reset_outputs", {18'd0, deb, press, rel, scan}, 32'd0);
    check("reset_outputs_n1", {28'd0, deb1, press1, rel1, scan1}, 32'd0);
    @(negedge clk);
    clear_counts();
    rst  = 1'b0;
    lat0 = -1;
    lat2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (lat0 < 0 && deb[0]) lat0 = n - 1;
      if (lat2 < 0 && deb[2]) lat2 = n - 1;
    end
    check_range("release_latency_ch0", lat0, LAT_LO, LAT_HI);
    check_range("release_latency_ch2", lat2, LAT_LO, LAT_HI);
    @(negedge clk);
    check("release_press_ch0", press_cnt[0], 1);
    check("release_press_ch2", press_cnt[2], 1);
    check("release_other_events", press_cnt[1] + press_cnt[3] + rel_cnt[0] + rel_cnt[2], 0);
    bouncy = '0;
    repeat (30) @(negedge clk);

    // Table-driven clean press / release vectors.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      clear_counts();
      bouncy[vecs[v].ch] = vecs[v].lvl;
      measure(vecs[v].ch, vecs[v].lvl, lat);
      check_range($sformatf("vec%0d_latency", v), lat, vecs[v].lo, vecs[v].hi);
      @(negedge clk);
      check($sformatf("vec%0d_press", v), press_cnt[vecs[v].ch], vecs[v].press_n);
      check($sformatf("vec%0d_release", v), rel_cnt[vecs[v].ch], vecs[v].rel_n);
      check($sformatf("vec%0d_total_events", v),
            press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] +
            rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3],
            vecs[v].press_n + vecs[v].rel_n);
    end

    // Glitch rejection on channel 2: 7 high / 3 low, ten times. Phase the
    // train so every low gap is seen by a channel-2 visit.
    hold = 0;
    while (hold < 8 && scan != 2'd2) begin
      @(negedge clk);
      hold++;
    end
    check("glitch_align", {30'd0, scan}, 32'd2);
    @(negedge clk);
    clear_counts();
    gmax = 0;
    for (int p = 0; p < 10; p++) begin
      bouncy[2] = 1'b1;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (int'(dut.count_reg[2]) > gmax) gmax = int'(dut.count_reg[2]);
      end
      bouncy[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (int'(dut.count_reg[2]) > gmax) gmax = int'(dut.count_reg[2]);
      end
    end
    repeat (20) @(negedge clk);
    check("glitch_debounced", {31'd0, deb[2]}, 32'd0);
    check("glitch_events", press_cnt[2] + rel_cnt[2], 0);
    check_range("glitch_max_count", gmax, 0, LIM - 1);

    // Simultaneous 0000 -> 1111.
    @(negedge clk);
    clear_counts();
    bouncy = 4'b1111;
    repeat (30) @(negedge clk);
    check("simul_event_count", ev_mask.size(), 4);
    if (ev_mask.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        pc = (int'(ev_scan[i]) + N - 1) % N;
        check($sformatf("simul_ev%0d_cycle", i), ev_cyc[i] - ev_cyc[0], i);
        check($sformatf("simul_ev%0d_channel", i), {28'd0, ev_mask[i]}, 32'd1 << pc);
      end
    end
    check("simul_debounced", {28'd0, deb}, 32'hF);
    bouncy = '0;
    repeat (30) @(negedge clk);

    // Reset mid-count on channel 3.
    bouncy[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("midcount_before_reset", {31'd0, deb[3]}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midcount_in_reset", {20'd0, deb, press, rel}, 32'd0);
    clear_counts();
    rst = 1'b0;
    measure(3, 1'b1, lat);
    check_range("midcount_after_release", lat, LAT_LO, LAT_HI);
    @(negedge clk);
    check("midcount_press", press_cnt[3], 1);
    bouncy = '0;
    repeat (30) @(negedge clk);

    // Randomized stimulus: mixes bursts of bouncing with long stable holds.
    for (int seg = 0; seg < 150; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) bouncy = 4'($urandom);
      else bouncy[$urandom_range(0, N - 1)] ^= 1'b1;
      hold = $urandom_range(1, 30);
      repeat (hold - 1) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // Minimum configuration: one channel, limit 1 -> follows in 2 cycles.
    clear_counts();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      b1  = ~b1;
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk);
        #1;
        if (lat < 0 && deb1 == b1) lat = n - 1;
      end
      check($sformatf("n1_toggle%0d_latency", t), lat, 2);
    end
    @(negedge clk);
    check("n1_press_count", press1_cnt, 2);
    check("n1_release_count", rel1_cnt, 2);
    check("n1_scan_idx", {31'd0, scan1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
